// File: rtl/simon_serial_core_p.sv
// Bit-serial Simon block cipher core, parametrised over the Simon family.
// Key and block are shifted in LSB first. The round-key file is expanded once
// per loaded key and reused for later encrypt/decrypt operations. The result
// is shifted out LSB first with out_valid framing.
module simon_serial_core_p #(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = 32,
    parameter int ZSEQ = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] data_rdy,
    input  logic       mode,
    output logic       busy,
    output logic       key_ready,
    output logic       out_valid,
    output logic       cipher_out
);

    localparam int KW = M * N;
    localparam int BW = 2 * N;
    localparam int CW = $clog2(T + 1);
    localparam int OW = $clog2(BW);

    localparam logic [CW-1:0] C_TLAST = CW'(T - 1);
    localparam logic [CW-1:0] C_M     = CW'(M);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [OW-1:0] C_OLAST = OW'(BW - 1);
    localparam logic [N-1:0]  C_THREE = N'(3);

    // z_j sequences written first-bit-leftmost; reversed so bit i is z[i].
    function automatic logic [61:0] z_rev(input int sel);
        logic [61:0] z;
        logic [61:0] r;
        case (sel)
            1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
            2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
            3:       z = 62'b11011011101011000110010111100000010010001010011100110100001111;
            4:       z = 62'b11010001111001101011011000100000010111000011001010010011101111;
            default: z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        endcase
        for (int j = 0; j < 62; j++) begin
            r[j] = z[61-j];
        end
        return r;
    endfunction

    localparam logic [61:0] Z_BITS = z_rev(ZSEQ);

    function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
        return (a << s) | (a >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
        return (a >> s) | (a << (N - s));
    endfunction

    function automatic logic [N-1:0] simon_f(input logic [N-1:0] a);
        return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_ROUND,
        S_OUTPUT
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_key_sr;
    logic [BW-1:0]   r_blk_sr;
    logic [N-1:0]    r_rk [0:T-1];
    logic [N-1:0]    r_win [0:M-1];   // sliding window rk[i-M..i-1]
    logic [CW-1:0]   r_i;             // expansion step index M..T-1
    logic [5:0]      r_z;             // z sequence bit index, wraps at 62
    logic [CW-1:0]   r_r;             // round index
    logic [OW-1:0]   r_ocnt;          // output bit counter
    logic            r_mode;
    logic            r_busy;
    logic            r_key_ready;
    logic            r_out_valid;
    logic            r_prev11;

    logic            w_start;
    logic            w_zbit;
    logic [N-1:0]    w_tmp_a;
    logic [N-1:0]    w_tmp;
    logic [N-1:0]    w_new_rk;
    logic [N-1:0]    w_x;
    logic [N-1:0]    w_y;
    logic [N-1:0]    w_rk;
    logic [BW-1:0]   w_enc;
    logic [BW-1:0]   w_dec;
    logic            w_round_last;

    // Start fires only on the first cycle of a data_rdy==11 run.
    assign w_start = (data_rdy == 2'b11) && !r_prev11;

    // Key-schedule step; the extra rk[i-3] term only exists for four-word keys.
    generate
        if (M == 4) begin : g_m4
            assign w_tmp_a = ror(r_win[M-1], 3) ^ r_win[1];
        end else begin : g_m23
            assign w_tmp_a = ror(r_win[M-1], 3);
        end
    endgenerate

    assign w_zbit   = Z_BITS[r_z];
    assign w_tmp    = w_tmp_a ^ ror(w_tmp_a, 1);
    assign w_new_rk = ~r_win[0] ^ w_tmp ^ {{(N-1){1'b0}}, w_zbit} ^ C_THREE;

    // One Feistel round in either direction on the block register.
    assign w_x   = r_blk_sr[BW-1:N];
    assign w_y   = r_blk_sr[N-1:0];
    assign w_rk  = r_rk[r_r];
    assign w_enc = {w_y ^ simon_f(w_x) ^ w_rk, w_x};
    assign w_dec = {w_y, w_x ^ simon_f(w_y) ^ w_rk};
    assign w_round_last = r_mode ? (r_r == '0) : (r_r == C_TLAST);

    assign busy       = r_busy;
    assign key_ready  = r_key_ready;
    assign out_valid  = r_out_valid;
    assign cipher_out = r_out_valid & r_blk_sr[0];

    // Control FSM with load shifters, key expansion, rounds and serial output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key_sr    <= '0;
            r_blk_sr    <= '0;
            for (int j = 0; j < T; j++) begin
                r_rk[j] <= '0;
            end
            for (int j = 0; j < M; j++) begin
                r_win[j] <= '0;
            end
            r_i         <= '0;
            r_z         <= '0;
            r_r         <= '0;
            r_ocnt      <= '0;
            r_mode      <= 1'b0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_prev11    <= 1'b0;
        end else begin
            r_prev11 <= (data_rdy == 2'b11);
            case (r_state)
                S_IDLE: begin
                    if (data_rdy == 2'b01) begin
                        r_key_sr    <= {data_in, r_key_sr[KW-1:1]};
                        r_key_ready <= 1'b0;
                    end else if (data_rdy == 2'b10) begin
                        r_blk_sr <= {data_in, r_blk_sr[BW-1:1]};
                    end else if (w_start) begin
                        r_busy <= 1'b1;
                        r_mode <= mode;
                        r_r    <= mode ? C_TLAST : '0;
                        if (!r_key_ready) begin
                            // Seed the file and window with the raw key words.
                            for (int j = 0; j < M; j++) begin
                                r_rk[j]  <= r_key_sr[j*N +: N];
                                r_win[j] <= r_key_sr[j*N +: N];
                            end
                            r_i     <= C_M;
                            r_z     <= '0;
                            r_state <= S_EXPAND;
                        end else begin
                            r_state <= S_ROUND;
                        end
                    end
                end
                S_EXPAND: begin
                    r_rk[r_i] <= w_new_rk;
                    for (int j = 0; j < M - 1; j++) begin
                        r_win[j] <= r_win[j+1];
                    end
                    r_win[M-1] <= w_new_rk;
                    r_z <= (r_z == 6'd61) ? 6'd0 : r_z + 6'd1;
                    if (r_i == C_TLAST) begin
                        r_key_ready <= 1'b1;
                        r_state     <= S_ROUND;
                    end else begin
                        r_i <= r_i + C_ONE;
                    end
                end
                S_ROUND: begin
                    r_blk_sr <= r_mode ? w_dec : w_enc;
                    r_r      <= r_mode ? r_r - C_ONE : r_r + C_ONE;
                    if (w_round_last) begin
                        r_out_valid <= 1'b1;
                        r_ocnt      <= '0;
                        r_state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    r_blk_sr <= {1'b0, r_blk_sr[BW-1:1]};
                    if (r_ocnt == C_OLAST) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_ocnt <= r_ocnt + OW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_serial_core_p.sv
// Testbench for simon_serial_core_p (Simon32/64 configuration).
// Expected results are queued when an operation starts and compared when
// the serial output burst completes.
module tb_simon_serial_core_p;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic [1:0] data_rdy;
    logic       mode;
    logic       busy;
    logic       key_ready;
    logic       out_valid;
    logic       cipher_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] PT  = 32'h6565_6877;
    localparam logic [31:0] CT  = 32'hc69b_e9bb;
    localparam logic [61:0] Z0  = 62'b11111010001001010110000111001101111101000100101011000011100110;

    simon_serial_core_p #(.N(16), .M(4), .T(32), .ZSEQ(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_rdy   (data_rdy),
        .mode       (mode),
        .busy       (busy),
        .key_ready  (key_ready),
        .out_valid  (out_valid),
        .cipher_out (cipher_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ror16(input logic [15:0] a, input int s);
        return (a >> s) | (a << (16 - s));
    endfunction

    function automatic logic [15:0] f16(input logic [15:0] a);
        logic [15:0] r1, r8, r2;
        r1 = {a[14:0], a[15]};
        r8 = {a[7:0], a[15:8]};
        r2 = {a[13:0], a[15:14]};
        return (r1 & r8) ^ r2;
    endfunction

    // Reference Simon32/64 written as a plain loop over the whole schedule.
    function automatic logic [31:0] simon_model(input logic [63:0] key, input logic [31:0] blk,
                                                input logic dec);
        logic [15:0] k [0:31];
        logic [15:0] t, x, y, tmp;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = ror16(k[i-1], 3) ^ k[i-3];
            t = t ^ ror16(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'd0, Z0[61-(i-4)]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (!dec) begin
            for (int i = 0; i < 32; i++) begin
                tmp = x; x = y ^ f16(x) ^ k[i]; y = tmp;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                tmp = y; y = x ^ f16(y) ^ k[i]; x = tmp;
            end
        end
        return {x, y};
    endfunction

    task automatic load_key(input logic [63:0] k);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); data_rdy = 2'b01; data_in = k[i];
        end
        @(negedge clk); data_rdy = 2'b00; data_in = 1'b0;
    endtask

    task automatic load_blk(input logic [31:0] b);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); data_rdy = 2'b10; data_in = b[i];
        end
        @(negedge clk); data_rdy = 2'b00; data_in = 1'b0;
    endtask

    // Start one operation, measure latency, collect the burst and score it.
    task automatic run_op(input logic md, input int hold, input bit noise,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        int cyc;
        int extra;
        logic [31:0] got;
        logic [31:0] e;
        exp_q.push_back(exp);
        lat = 0;
        cyc = 0;
        extra = 0;
        got = '0;
        @(negedge clk); data_rdy = 2'b11; mode = md;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_at_start got %b want 1", name, busy);
        end
        for (int k = 1; k <= 300; k++) begin
            if (noise) begin
                data_rdy = 2'($urandom_range(1, 2)); data_in = 1'($urandom);
            end else begin
                data_rdy = (cyc + 1 < hold) ? 2'b11 : 2'b00;
            end
            mode = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        for (int b = 0; b < 32; b++) begin
            got[b] = cipher_out;
            if (noise && b < 16) begin
                data_rdy = 2'($urandom_range(1, 2)); data_in = 1'($urandom);
            end else begin
                data_rdy = (!noise && cyc + 1 < hold) ? 2'b11 : 2'b00;
            end
            @(posedge clk); #1;
            cyc++;
        end
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL %s data got %h want %h", name, got, e);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cipher_out !== 1'b0) begin
            errors++;
            $display("FAIL %s end_of_burst got valid=%b busy=%b out=%b want 0 0 0",
                     name, out_valid, busy, cipher_out);
        end
        while (cyc < hold) begin
            data_rdy = (cyc + 1 < hold) ? 2'b11 : 2'b00;
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1 || out_valid === 1'b1) extra++;
        end
        if (hold > 1) begin
            checks++;
            if (extra != 0) begin
                errors++; $display("FAIL %s restart_while_held got %0d active cycles want 0", name, extra);
            end
        end
        data_rdy = 2'b00;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++; $display("FAIL %s key_ready_after got %b want 1", name, key_ready);
        end
        $display("op %s mode=%0d result=%h expected=%h latency=%0d", name, md, got, e, lat);
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || key_ready !== 1'b0 || out_valid !== 1'b0 || cipher_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b kr=%b valid=%b out=%b want 0 0 0 0",
                     busy, key_ready, out_valid, cipher_out);
        end
        $display("reset state checked");
    endtask

    task automatic test_encrypt();
        load_key(KEY);
        load_blk(PT);
        run_op(1'b0, 1, 1'b0, CT, 60, "encrypt");
    endtask

    task automatic test_decrypt_cached();
        load_blk(CT);
        run_op(1'b1, 1, 1'b0, PT, 32, "decrypt_cached");
    endtask

    task automatic test_hold_start();
        load_blk(PT);
        run_op(1'b0, 100, 1'b0, CT, 32, "hold_start");
    endtask

    task automatic test_busy_lockout();
        load_blk(PT);
        run_op(1'b0, 1, 1'b1, CT, 32, "busy_lockout");
    endtask

    task automatic test_async_reset();
        int seen;
        seen = 0;
        load_blk(PT);
        @(negedge clk); data_rdy = 2'b11; mode = 1'b0;
        @(posedge clk); #1; data_rdy = 2'b00;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || key_ready !== 1'b0 || cipher_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b valid=%b kr=%b out=%b want 0 0 0 0",
                     busy, out_valid, key_ready, cipher_out);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL post_reset_quiet got %0d active cycles want 0", seen);
        end
        $display("async reset mid-round checked");
        load_key(KEY);
        load_blk(PT);
        run_op(1'b0, 1, 1'b0, CT, 60, "after_reset");
    endtask

    task automatic test_key_reload();
        @(negedge clk); data_rdy = 2'b01; data_in = KEY[0];
        @(posedge clk); #1; data_rdy = 2'b00;
        checks++;
        if (key_ready !== 1'b0) begin
            errors++; $display("FAIL key_reload_clear got %b want 0", key_ready);
        end
        load_key(KEY);
        load_blk(PT);
        run_op(1'b0, 1, 1'b0, CT, 60, "key_reload");
    endtask

    task automatic test_random_roundtrip();
        logic [63:0] k;
        logic [31:0] p;
        logic [31:0] c;
        for (int n = 0; n < 2; n++) begin
            k = {$urandom, $urandom};
            p = $urandom;
            c = simon_model(k, p, 1'b0);
            load_key(k);
            load_blk(p);
            run_op(1'b0, 1, 1'b0, c, 60, "rand_enc");
            load_blk(c);
            run_op(1'b1, 1, 1'b0, p, 32, "rand_dec");
        end
    endtask

    initial begin
        rst = 1'b1;
        data_in = 1'b0;
        data_rdy = 2'b00;
        mode = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_encrypt();
        test_decrypt_cached();
        test_hold_start();
        test_busy_lockout();
        test_async_reset();
        test_key_reload();
        test_random_roundtrip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
